ram_recur_engine: RTL

//   Parametrised successor to the fixed 32-entry running-sum RAM filler. Drives a

---
 rtl/ram_recur_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ram_recur_engine.sv
// ram_recur_engine: fills len words of a simple dual-port BRAM (port A write,
// port B read, 1-cycle read latency) starting at base_addr, either with an
// in-place prefix sum (mode 0) or a Fibonacci sequence (mode 1).
// Optional macro SAT_ADD_EN: saturating adder (default build wraps).
module ram_recur_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_wea,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [2:0] {
        IDLE, SEED0, SEED1, RD, WT, WR, FIN
    } state_t;

    state_t state, state_nxt;

    logic              mode_q, mode_nxt;
    logic [ADDR_W:0]   rem, rem_nxt;
    logic [ADDR_W-1:0] k, k_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [DATA_W-1:0] seed0_q, seed0_nxt;
    logic [DATA_W-1:0] seed1_q, seed1_nxt;

    logic [DATA_W-1:0] din_nxt;
    logic [ADDR_W-1:0] addra_nxt, addrb_nxt;
    logic              wea_nxt, busy_nxt, done_nxt, ovf_nxt;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] wdata;
    logic              last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Adder with carry-out; the carry drives ovf and, optionally, saturation.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, ram_dout};
`ifdef SAT_ADD_EN
        wdata = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
        wdata = sum[DATA_W-1:0];
`endif
    end

    // rem counts words still to be written, so rem == 1 marks the final write.
    assign last = (rem == (ADDR_W+1)'(1));

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) state_nxt = FIN;
                    else if (mode) state_nxt = SEED0;
                    else           state_nxt = RD;
                end
            end
            SEED0:   state_nxt = last ? FIN : SEED1;
            SEED1:   state_nxt = last ? FIN : RD;
            RD:      state_nxt = WT;
            WT:      state_nxt = WR;
            WR:      state_nxt = last ? FIN : RD;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; everything is registered below.
    always_comb begin
        mode_nxt  = mode_q;
        rem_nxt   = rem;
        k_nxt     = k;
        acc_nxt   = acc;
        seed0_nxt = seed0_q;
        seed1_nxt = seed1_q;
        din_nxt   = ram_din;
        addra_nxt = ram_addra;
        addrb_nxt = ram_addrb;
        wea_nxt   = 1'b0;
        done_nxt  = 1'b0;
        busy_nxt  = 1'b1;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                busy_nxt = start;
                if (start) begin
                    mode_nxt  = mode;
                    rem_nxt   = len;
                    k_nxt     = base_addr;
                    seed0_nxt = seed0;
                    seed1_nxt = seed1;
                    acc_nxt   = seed0;
                    ovf_nxt   = 1'b0;
                end
            end
            SEED0: begin
                wea_nxt   = 1'b1;
                addra_nxt = k;
                din_nxt   = seed0_q;
                acc_nxt   = seed0_q;
                rem_nxt   = rem - 1'b1;
                k_nxt     = k + 1'b1;
            end
            SEED1: begin
                wea_nxt   = 1'b1;
                addra_nxt = k;
                din_nxt   = seed1_q;
                acc_nxt   = seed1_q;
                rem_nxt   = rem - 1'b1;
                k_nxt     = k + 1'b1;
            end
            RD: begin
                // FIB reads two words back; acc already holds mem[k-1].
                addrb_nxt = mode_q ? (k - ADDR_W'(2)) : k;
            end
            WT: begin
            end
            WR: begin
                wea_nxt   = 1'b1;
                addra_nxt = k;
                din_nxt   = wdata;
                acc_nxt   = wdata;
                if (sum[DATA_W]) ovf_nxt = 1'b1;
                rem_nxt   = rem - 1'b1;
                k_nxt     = k + 1'b1;
            end
            FIN: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= 1'b0;
            rem       <= '0;
            k         <= '0;
            acc       <= '0;
            seed0_q   <= '0;
            seed1_q   <= '0;
            ram_din   <= '0;
            ram_addra <= '0;
            ram_addrb <= '0;
            ram_wea   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            mode_q    <= mode_nxt;
            rem       <= rem_nxt;
            k         <= k_nxt;
            acc       <= acc_nxt;
            seed0_q   <= seed0_nxt;
            seed1_q   <= seed1_nxt;
            ram_din   <= din_nxt;
            ram_addra <= addra_nxt;
            ram_addrb <= addrb_nxt;
            ram_wea   <= wea_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            ovf       <= ovf_nxt;
        end
    end

endmodule
